// File: rtl/csr_machine_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, trap causes,
// reset values and the architectural register bundle.
package csr_machine_pkg;

  localparam logic [11:0] csr_mstatus       = 12'h300;
  localparam logic [11:0] csr_misa          = 12'h301;
  localparam logic [11:0] csr_mie           = 12'h304;
  localparam logic [11:0] csr_mtvec         = 12'h305;
  localparam logic [11:0] csr_mcountinhibit = 12'h320;
  localparam logic [11:0] csr_mhpmevent3    = 12'h323;
  localparam logic [11:0] csr_mscratch      = 12'h340;
  localparam logic [11:0] csr_mepc          = 12'h341;
  localparam logic [11:0] csr_mcause        = 12'h342;
  localparam logic [11:0] csr_mtval         = 12'h343;
  localparam logic [11:0] csr_mip           = 12'h344;
  localparam logic [11:0] csr_mcycle        = 12'hB00;
  localparam logic [11:0] csr_minstret      = 12'hB02;
  localparam logic [11:0] csr_mhpmcounter3  = 12'hB03;
  localparam logic [11:0] csr_mcycleh       = 12'hB80;
  localparam logic [11:0] csr_minstreth     = 12'hB82;
  localparam logic [11:0] csr_mhpmcounter3h = 12'hB83;
  localparam logic [11:0] csr_cycle         = 12'hC00;
  localparam logic [11:0] csr_time          = 12'hC01;
  localparam logic [11:0] csr_instret       = 12'hC02;
  localparam logic [11:0] csr_hpmcounter3   = 12'hC03;
  localparam logic [11:0] csr_cycleh        = 12'hC80;
  localparam logic [11:0] csr_timeh         = 12'hC81;
  localparam logic [11:0] csr_instreth      = 12'hC82;
  localparam logic [11:0] csr_hpmcounter3h  = 12'hC83;
  localparam logic [11:0] csr_mvendorid     = 12'hF11;
  localparam logic [11:0] csr_marchid       = 12'hF12;
  localparam logic [11:0] csr_mimpid        = 12'hF13;
  localparam logic [11:0] csr_mhartid       = 12'hF14;

  localparam logic [31:0] cause_m_ext   = 32'h8000_000B;
  localparam logic [31:0] cause_m_soft  = 32'h8000_0003;
  localparam logic [31:0] cause_m_timer = 32'h8000_0007;

  localparam logic [31:0] misa_value        = 32'h4000_1104;
  localparam logic [1:0]  mstatus_mpp_reset = 2'b11;
  localparam logic [31:0] mie_wmask         = 32'h0000_0888;

  typedef struct packed {
    logic        st_mie;
    logic        st_mpie;
    logic [1:0]  st_mpp;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mcountinhibit;
    logic        mip_meip;
    logic        mip_mtip;
    logic        mip_msip;
  } csr_regs_t;

  function automatic logic [31:0] mstatus_read(input csr_regs_t r);
    return {19'b0, r.st_mpp, 3'b0, r.st_mpie, 3'b0, r.st_mie, 3'b0};
  endfunction

  function automatic logic [31:0] mip_read(input csr_regs_t r);
    return {20'b0, r.mip_meip, 3'b0, r.mip_mtip, 3'b0, r.mip_msip, 3'b0};
  endfunction

endpackage

// File: rtl/csr_machine_counter.sv
// One CNT_WIDTH-bit performance counter with split 32-bit half writes.
// A half write wins over the increment in the same cycle.
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_inhibit,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic [31:0]          i_wdata,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_wr_lo) begin
      r_count[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_count[CNT_WIDTH-1:32] <= i_wdata[CNT_WIDTH-33:0];
    end else if (i_inc && !i_inhibit) begin
      r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_machine.sv
// Machine-mode CSR unit: combinational reads, execute-stage writes, trap
// entry/return and a parametrised bank of performance counters.
module csr_machine
  import csr_machine_pkg::*;
#(
  parameter int          NUM_HPM    = 4,
  parameter int          NUM_EVENTS = 8,
  parameter int          CNT_WIDTH  = 64,
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [31:0] RESET_VEC  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [11:0]           rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [11:0]           wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  valid,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  input  logic                  exc,
  input  logic [3:0]            exc_cause,
  input  logic [31:0]           exc_epc,
  input  logic [31:0]           exc_tval,
  input  logic                  mret,
  input  logic                  meip,
  input  logic                  mtip,
  input  logic                  msip,
  input  logic [63:0]           mtime,
  output logic                  trap_out,
  output logic                  mret_out,
  output logic [31:0]           mepc_out,
  output logic [31:0]           mtvec_out
);

  localparam int NUM_CNT = 2 + NUM_HPM;
  localparam int HPM_N   = (NUM_HPM > 0) ? NUM_HPM : 1;

  function automatic logic [31:0] f_inhibit_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] inhibit_mask = f_inhibit_mask();

  csr_regs_t         r_csr;
  logic [31:0]       r_mhpmevent [HPM_N];
  logic              r_trap_out;
  logic              r_mret_out;

  logic [CNT_WIDTH-1:0] w_count   [NUM_CNT];
  logic [63:0]          w_count64 [NUM_CNT];
  logic [NUM_CNT-1:0]   w_inc;
  logic [NUM_CNT-1:0]   w_inhibit;
  logic [NUM_CNT-1:0]   w_wr_lo;
  logic [NUM_CNT-1:0]   w_wr_hi;

  logic              w_int_en;
  logic              w_take_ext;
  logic              w_take_soft;
  logic              w_take_tmr;
  logic              w_trap;
  logic [31:0]       w_cause;
  logic [31:0]       w_rd_data;
  logic [31:0]       w_tvec_base;

  // Counter slot 0 is mcycle, slot 1 minstret, slots 2.. the hpm counters.
  always_comb begin
    w_inc     = '0;
    w_inhibit = '0;
    w_wr_lo   = '0;
    w_wr_hi   = '0;
    w_inc[0]     = 1'b1;
    w_inc[1]     = valid;
    w_inhibit[0] = r_csr.mcountinhibit[0];
    w_inhibit[1] = r_csr.mcountinhibit[2];
    w_wr_lo[0]   = wr_en && (wr_addr == csr_mcycle);
    w_wr_hi[0]   = wr_en && (wr_addr == csr_mcycleh);
    w_wr_lo[1]   = wr_en && (wr_addr == csr_minstret);
    w_wr_hi[1]   = wr_en && (wr_addr == csr_minstreth);
    for (int i = 0; i < NUM_HPM; i++) begin
      w_inhibit[2+i] = r_csr.mcountinhibit[3+i];
      w_wr_lo[2+i]   = wr_en && (wr_addr == csr_mhpmcounter3 + 12'(i));
      w_wr_hi[2+i]   = wr_en && (wr_addr == csr_mhpmcounter3h + 12'(i));
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (r_mhpmevent[i] == 32'(e + 1) && hpm_event[e]) w_inc[2+i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    csr_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_inc[g]),
      .i_inhibit(w_inhibit[g]),
      .i_wr_lo  (w_wr_lo[g]),
      .i_wr_hi  (w_wr_hi[g]),
      .i_wdata  (wr_data),
      .o_count  (w_count[g])
    );
    assign w_count64[g] = 64'(w_count[g]);
  end

  // Interrupts are only taken on a retiring instruction; exceptions always win.
  always_comb begin
    w_int_en    = r_csr.st_mie & valid;
    w_take_ext  = w_int_en & r_csr.mie[11] & r_csr.mip_meip;
    w_take_soft = w_int_en & r_csr.mie[3]  & r_csr.mip_msip;
    w_take_tmr  = w_int_en & r_csr.mie[7]  & r_csr.mip_mtip;
    w_trap      = exc | w_take_ext | w_take_soft | w_take_tmr;
    if (exc)              w_cause = {28'b0, exc_cause};
    else if (w_take_ext)  w_cause = cause_m_ext;
    else if (w_take_soft) w_cause = cause_m_soft;
    else                  w_cause = cause_m_timer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csr        <= '0;
      r_csr.st_mpp <= mstatus_mpp_reset;
      r_csr.mtvec  <= RESET_VEC;
      for (int i = 0; i < HPM_N; i++) r_mhpmevent[i] <= '0;
      r_trap_out   <= 1'b0;
      r_mret_out   <= 1'b0;
    end else begin
      r_csr.mip_meip <= meip;
      r_csr.mip_mtip <= mtip;
      r_csr.mip_msip <= msip;
      if (wr_en) begin
        case (wr_addr)
          csr_mstatus: begin
            if (!w_trap) begin
              r_csr.st_mie  <= wr_data[3];
              r_csr.st_mpie <= wr_data[7];
              if (wr_data[12:11] == 2'b11 || wr_data[12:11] == 2'b00)
                r_csr.st_mpp <= wr_data[12:11];
            end
          end
          csr_mie:           r_csr.mie <= wr_data & mie_wmask;
          csr_mtvec:         r_csr.mtvec <= {wr_data[31:2], wr_data[1] ? 2'b00 : wr_data[1:0]};
          csr_mscratch:      r_csr.mscratch <= wr_data;
          csr_mepc:          r_csr.mepc <= wr_data;
          csr_mcause:        r_csr.mcause <= wr_data;
          csr_mtval:         r_csr.mtval <= wr_data;
          csr_mcountinhibit: r_csr.mcountinhibit <= wr_data & inhibit_mask;
          default: ;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
          if (wr_addr == csr_mhpmevent3 + 12'(i)) r_mhpmevent[i] <= wr_data;
        end
      end
      // Trap entry is placed last so it overrides same-cycle writes and mret.
      if (w_trap) begin
        r_csr.st_mpie <= r_csr.st_mie;
        r_csr.st_mie  <= 1'b0;
        r_csr.mepc    <= exc_epc;
        r_csr.mtval   <= exc ? exc_tval : 32'h0;
        r_csr.mcause  <= w_cause;
      end else if (mret) begin
        r_csr.st_mie  <= r_csr.st_mpie;
        r_csr.st_mpie <= 1'b1;
      end
      r_trap_out <= w_trap;
      r_mret_out <= mret & ~w_trap;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (rd_en) begin
      case (rd_addr)
        csr_misa:                  w_rd_data = misa_value;
        csr_mhartid:               w_rd_data = HART_ID;
        csr_mstatus:               w_rd_data = mstatus_read(r_csr);
        csr_mie:                   w_rd_data = r_csr.mie;
        csr_mip:                   w_rd_data = mip_read(r_csr);
        csr_mtvec:                 w_rd_data = r_csr.mtvec;
        csr_mscratch:              w_rd_data = r_csr.mscratch;
        csr_mepc:                  w_rd_data = r_csr.mepc;
        csr_mcause:                w_rd_data = r_csr.mcause;
        csr_mtval:                 w_rd_data = r_csr.mtval;
        csr_mcountinhibit:         w_rd_data = r_csr.mcountinhibit;
        csr_mcycle,   csr_cycle:   w_rd_data = w_count64[0][31:0];
        csr_mcycleh,  csr_cycleh:  w_rd_data = w_count64[0][63:32];
        csr_minstret, csr_instret: w_rd_data = w_count64[1][31:0];
        csr_minstreth, csr_instreth: w_rd_data = w_count64[1][63:32];
        csr_time:                  w_rd_data = mtime[31:0];
        csr_timeh:                 w_rd_data = mtime[63:32];
        default:                   w_rd_data = '0;
      endcase
      for (int i = 0; i < NUM_HPM; i++) begin
        if (rd_addr == csr_mhpmcounter3 + 12'(i) || rd_addr == csr_hpmcounter3 + 12'(i))
          w_rd_data = w_count64[2+i][31:0];
        if (rd_addr == csr_mhpmcounter3h + 12'(i) || rd_addr == csr_hpmcounter3h + 12'(i))
          w_rd_data = w_count64[2+i][63:32];
        if (rd_addr == csr_mhpmevent3 + 12'(i))
          w_rd_data = r_mhpmevent[i];
      end
    end
  end

  assign w_tvec_base = {r_csr.mtvec[31:2], 2'b00};

  always_comb begin
    mtvec_out = w_tvec_base;
    if (r_csr.mtvec[1:0] == 2'b01 && r_csr.mcause[31])
      mtvec_out = w_tvec_base + {25'b0, r_csr.mcause[4:0], 2'b00};
  end

  assign rd_data  = w_rd_data;
  assign mepc_out = {r_csr.mepc[31:2], 2'b00};
  assign trap_out = r_trap_out;
  assign mret_out = r_mret_out;

endmodule

// File: tb/tb_csr_machine.sv
// Self-checking bench for csr_machine: randomized counter traffic against a
// behavioural counter model, then directed trap, mret, wrap and reset steps.
`timescale 1ns/1ps
module tb_csr_machine;

  localparam int          NUM_HPM    = 4;
  localparam int          NUM_EVENTS = 8;
  localparam int          CNT_WIDTH  = 40;
  localparam logic [31:0] HART_ID    = 32'h0000_0005;
  localparam logic [31:0] RESET_VEC  = 32'h0000_1000;

  localparam logic [11:0] a_mstatus = 12'h300, a_misa = 12'h301, a_mie = 12'h304;
  localparam logic [11:0] a_mtvec = 12'h305, a_minh = 12'h320, a_mhpmevent3 = 12'h323;
  localparam logic [11:0] a_mscratch = 12'h340, a_mepc = 12'h341, a_mcause = 12'h342;
  localparam logic [11:0] a_mtval = 12'h343, a_mip = 12'h344;
  localparam logic [11:0] a_mcycle = 12'hB00, a_minstret = 12'hB02, a_mhpmcounter3 = 12'hB03;
  localparam logic [11:0] a_mcycleh = 12'hB80, a_cycle = 12'hC00, a_time = 12'hC01;
  localparam logic [11:0] a_hpmcounter3 = 12'hC03, a_timeh = 12'hC81, a_mhartid = 12'hF14;

  logic                  clk;
  logic                  rst;
  logic                  rd_en;
  logic [11:0]           rd_addr;
  logic [31:0]           rd_data;
  logic                  wr_en;
  logic [11:0]           wr_addr;
  logic [31:0]           wr_data;
  logic                  valid;
  logic [NUM_EVENTS-1:0] hpm_event;
  logic                  exc;
  logic [3:0]            exc_cause;
  logic [31:0]           exc_epc;
  logic [31:0]           exc_tval;
  logic                  mret;
  logic                  meip;
  logic                  mtip;
  logic                  msip;
  logic [63:0]           mtime;
  logic                  trap_out;
  logic                  mret_out;
  logic [31:0]           mepc_out;
  logic [31:0]           mtvec_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  csr_machine #(
    .NUM_HPM   (NUM_HPM),
    .NUM_EVENTS(NUM_EVENTS),
    .CNT_WIDTH (CNT_WIDTH),
    .HART_ID   (HART_ID),
    .RESET_VEC (RESET_VEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .valid    (valid),
    .hpm_event(hpm_event),
    .exc      (exc),
    .exc_cause(exc_cause),
    .exc_epc  (exc_epc),
    .exc_tval (exc_tval),
    .mret     (mret),
    .meip     (meip),
    .mtip     (mtip),
    .msip     (msip),
    .mtime    (mtime),
    .trap_out (trap_out),
    .mret_out (mret_out),
    .mepc_out (mepc_out),
    .mtvec_out(mtvec_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    rd_en   = 1'b1;
    rd_addr = addr;
    #1;
    data    = rd_data;
    rd_en   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(addr, v);
    check(tag, v, exp);
  endtask

  // behavioural counter model
  logic [63:0] m_cyc, m_ret;
  logic [63:0] m_hpm [NUM_HPM];
  logic [31:0] m_evt [NUM_HPM];
  logic [31:0] m_inh;
  logic [31:0] m_mask;

  initial begin
    logic [31:0] v, d, prev;
    logic [7:0]  ev;
    int          op, k;
    logic [63:0] wrapped;

    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    valid = 1'b0; hpm_event = '0; exc = 1'b0; exc_cause = '0; exc_epc = '0; exc_tval = '0;
    mret = 1'b0; meip = 1'b0; mtip = 1'b0; msip = 1'b0; mtime = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_trap_out", {31'b0, trap_out}, 32'h0);
    check("rst_mret_out", {31'b0, mret_out}, 32'h0);
    check_csr("rst_misa", a_misa, 32'h4000_1104);
    check_csr("rst_mstatus", a_mstatus, 32'h0000_1800);
    check_csr("rst_mtvec", a_mtvec, RESET_VEC);
    check_csr("rst_mhartid", a_mhartid, HART_ID);
    check_csr("rst_mcycle", a_mcycle, 32'h0);
    check("rst_mtvec_out", mtvec_out, RESET_VEC);
    check("rst_mepc_out", mepc_out, 32'h0);

    // randomized counter traffic
    m_cyc = 0; m_ret = 0; m_inh = 0;
    m_mask = 32'h0000_0005;
    for (int i = 0; i < NUM_HPM; i++) begin
      m_hpm[i] = 0; m_evt[i] = 0; m_mask[3+i] = 1'b1;
    end
    for (int it = 0; it < 80; it++) begin
      valid     = 1'($urandom_range(0, 1));
      ev        = 8'($urandom_range(0, 255));
      hpm_event = ev;
      op        = $urandom_range(0, 3);
      d         = $urandom;
      k         = $urandom_range(0, NUM_HPM - 1);
      if (it == 79) begin
        op = 1;
        d  = 32'hFFFF_FFFF;
      end
      if (op == 2) d = 32'($urandom_range(0, 10));
      wr_en   = (op == 1 || op == 2);
      wr_addr = (op == 2) ? a_mhpmevent3 + 12'(k) : a_minh;
      wr_data = d;
      if (!m_inh[0]) m_cyc++;
      if (valid && !m_inh[2]) m_ret++;
      for (int i = 0; i < NUM_HPM; i++) begin
        if (m_evt[i] >= 1 && m_evt[i] <= NUM_EVENTS && !m_inh[3+i])
          if (ev[m_evt[i] - 1]) m_hpm[i]++;
      end
      if (op == 1) m_inh = d & m_mask;
      if (op == 2) m_evt[k] = d;
      tick();
      wr_en = 1'b0;
    end
    valid = 1'b0;
    hpm_event = '0;

    exp_q.push_back(m_cyc[31:0]);
    csr_read(a_mcycle, v);
    check("rnd_mcycle", v, exp_q.pop_front());
    exp_q.push_back(m_ret[31:0]);
    csr_read(a_minstret, v);
    check("rnd_minstret", v, exp_q.pop_front());
    for (int i = 0; i < NUM_HPM; i++) begin
      exp_q.push_back(m_hpm[i][31:0]);
      csr_read(a_mhpmcounter3 + 12'(i), v);
      check("rnd_mhpmcounter", v, exp_q.pop_front());
      exp_q.push_back(m_evt[i]);
      csr_read(a_mhpmevent3 + 12'(i), v);
      check("rnd_mhpmevent", v, exp_q.pop_front());
    end
    check_csr("rnd_cycle_shadow", a_cycle, m_cyc[31:0]);
    check_csr("minh_mask", a_minh, m_mask);

    // hpm counting with a two-cycle inhibit window
    csr_write(a_mhpmevent3, 32'd2);
    csr_write(a_mhpmcounter3, 32'h0);
    csr_write(a_minh, 32'h0);
    hpm_event = 8'h02;
    csr_write(a_minh, 32'h8);
    tick();
    csr_write(a_minh, 32'h0);
    tick();
    tick();
    hpm_event = '0;
    check_csr("hpm3_count", a_mhpmcounter3, 32'd3);
    check_csr("hpm3_shadow", a_hpmcounter3, 32'd3);
    csr_write(a_mhpmevent3, 32'd9);
    hpm_event = 8'hFF;
    tick();
    tick();
    tick();
    hpm_event = '0;
    check_csr("hpm3_evt9", a_mhpmcounter3, 32'd3);
    csr_write(12'hB0A, 32'h1234_5678);
    check_csr("unimpl_hpm", 12'hB0A, 32'h0);
    check_csr("unimpl_evt", 12'h32A, 32'h0);
    check_csr("unknown_addr", 12'h7C0, 32'h0);
    rd_en = 1'b0; rd_addr = a_misa; #1;
    check("rd_en_low", rd_data, 32'h0);

    // 40-bit counter width and wrap
    csr_write(a_mcycleh, 32'hABCD_EF12);
    check_csr("mcycleh_width", a_mcycleh, 32'h0000_0012);
    csr_write(a_mcycleh, 32'h0000_00FF);
    csr_write(a_mcycle, 32'hFFFF_FFFF);
    check_csr("mcycle_wr_noinc", a_mcycle, 32'hFFFF_FFFF);
    check_csr("mcycleh_wr", a_mcycleh, 32'h0000_00FF);
    tick();
    wrapped = ((64'hFF << 32) + 64'hFFFF_FFFF + 64'd1) % (64'd1 << CNT_WIDTH);
    check_csr("mcycle_wrap", a_mcycle, wrapped[31:0]);
    check_csr("mcycleh_wrap", a_mcycleh, wrapped[63:32]);

    // external + timer together: external wins, vectored target
    exc_epc = 32'h0000_0201; exc_tval = 32'hDEAD_BEEF;
    csr_write(a_mie, 32'h0000_0888);
    csr_write(a_mtvec, 32'h0000_0101);
    csr_write(a_mstatus, 32'h0000_1808);
    check_csr("mie_wr", a_mie, 32'h0000_0888);
    check_csr("mstatus_wr", a_mstatus, 32'h0000_1808);
    meip = 1'b1; mtip = 1'b1; valid = 1'b1;
    tick();
    check("ext_latency", {31'b0, trap_out}, 32'h0);
    check_csr("mip_read", a_mip, 32'h0000_0880);
    tick();
    check("ext_trap_out", {31'b0, trap_out}, 32'h1);
    check_csr("ext_mcause", a_mcause, 32'h8000_000B);
    check("ext_mtvec_out", mtvec_out, 32'h0000_012C);
    check("ext_mepc_out", mepc_out, 32'h0000_0200);
    check_csr("ext_mtval", a_mtval, 32'h0);
    check_csr("ext_mstatus", a_mstatus, 32'h0000_1880);
    valid = 1'b0; meip = 1'b0; mtip = 1'b0;
    tick();
    check("ext_pulse_end", {31'b0, trap_out}, 32'h0);

    // exception beats mret and a same-cycle mepc write
    exc = 1'b1; exc_cause = 4'd2; mret = 1'b1;
    exc_epc = 32'h0000_0300; exc_tval = 32'h0000_1234;
    csr_write(a_mepc, 32'h0000_0040);
    exc = 1'b0; mret = 1'b0;
    check("exc_trap_out", {31'b0, trap_out}, 32'h1);
    check("exc_mret_out", {31'b0, mret_out}, 32'h0);
    check_csr("exc_mepc", a_mepc, 32'h0000_0300);
    check_csr("exc_mcause", a_mcause, 32'h0000_0002);
    check_csr("exc_mtval", a_mtval, 32'h0000_1234);
    check_csr("exc_mstatus", a_mstatus, 32'h0000_1800);
    check("exc_mtvec_out", mtvec_out, 32'h0000_0100);

    // mret with mpie set
    csr_write(a_mstatus, 32'h0000_1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_out", {31'b0, mret_out}, 32'h1);
    check_csr("mret_mstatus", a_mstatus, 32'h0000_1888);
    check("mret_mepc_out", mepc_out, 32'h0000_0300);
    tick();
    check("mret_pulse_end", {31'b0, mret_out}, 32'h0);

    mtime = 64'h1_0000_0005;
    check_csr("timeh", a_timeh, 32'h1);
    check_csr("time", a_time, 32'h5);

    // software beats timer
    msip = 1'b1; mtip = 1'b1; valid = 1'b1;
    tick();
    tick();
    check("sw_trap_out", {31'b0, trap_out}, 32'h1);
    check_csr("sw_mcause", a_mcause, 32'h8000_0003);
    check("sw_mtvec_out", mtvec_out, 32'h0000_010C);
    msip = 1'b0; valid = 1'b0;

    // timer waits for a retiring instruction
    csr_write(a_mstatus, 32'h0000_1808);
    tick();
    tick();
    check("tmr_no_valid", {31'b0, trap_out}, 32'h0);
    valid = 1'b1;
    tick();
    valid = 1'b0; mtip = 1'b0;
    check("tmr_trap_out", {31'b0, trap_out}, 32'h1);
    check_csr("tmr_mcause", a_mcause, 32'h8000_0007);
    check("tmr_mtvec_out", mtvec_out, 32'h0000_011C);

    // mscratch: same-cycle read sees old value, next cycle sees new
    prev = 32'h0;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      wr_en = 1'b1; wr_addr = a_mscratch; wr_data = d;
      check_csr("mscratch_old", a_mscratch, prev);
      tick();
      wr_en = 1'b0;
      csr_read(a_mscratch, v);
      prev = exp_q.pop_front();
      check("mscratch_new", v, prev);
    end

    // reset in the middle of a pending trap and mret
    exc = 1'b1; exc_cause = 4'd5; mret = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; exc = 1'b0; mret = 1'b0;
    check("mid_rst_trap", {31'b0, trap_out}, 32'h0);
    check("mid_rst_mret", {31'b0, mret_out}, 32'h0);
    check_csr("mid_rst_mstatus", a_mstatus, 32'h0000_1800);
    check_csr("mid_rst_mcause", a_mcause, 32'h0);
    check_csr("mid_rst_mscratch", a_mscratch, 32'h0);
    check_csr("mid_rst_mtvec", a_mtvec, RESET_VEC);
    tick();
    check("post_rst_trap", {31'b0, trap_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
